// File: rtl/eth_pattern_gen_if.sv
// rtl/eth_pattern_gen_if.sv - Ethernet frame interface (header handshake plus 8-bit payload stream)
// Purpose: carries one Ethernet frame from a frame source to eth_axis_tx.
// Ports:
//   hdr_valid/hdr_ready    header handshake; dest_mac, src_mac and eth_type qualify it
//   payload_tdata/tvalid/tready/tlast/tuser  8-bit payload stream
// Modports: master = frame source, slave = frame sink.
interface eth_pattern_gen_if;
  logic        hdr_valid;
  logic        hdr_ready;
  logic [47:0] dest_mac;
  logic [47:0] src_mac;
  logic [15:0] eth_type;
  logic [7:0]  payload_tdata;
  logic        payload_tvalid;
  logic        payload_tready;
  logic        payload_tlast;
  logic        payload_tuser;

  modport master (
    output hdr_valid, dest_mac, src_mac, eth_type,
    output payload_tdata, payload_tvalid, payload_tlast, payload_tuser,
    input  hdr_ready, payload_tready
  );

  modport slave (
    input  hdr_valid, dest_mac, src_mac, eth_type,
    input  payload_tdata, payload_tvalid, payload_tlast, payload_tuser,
    output hdr_ready, payload_tready
  );
endinterface

// File: rtl/eth_pattern_gen.sv
// rtl/eth_pattern_gen.sv - sequence-numbered, timestamped Ethernet test-frame generator
// Purpose: emits pattern frames in burst, continuous or length-sweep mode with a
//   programmable inter-packet gap.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   cfg_*                 run configuration, latched on an accepted cfg_start
//   timestamp             free-running count, captured at header accept
//   eth (master)          header handshake plus payload stream towards eth_axis_tx
//   busy                  generator is not idle
//   sent_count            frames completed since the last accepted start
module eth_pattern_gen #(
  parameter int          LEN_WIDTH = 11,
  parameter int          MIN_LEN   = 4,
  parameter int          MAX_LEN   = 1500,
  parameter logic [15:0] ETH_TYPE  = 16'h88B5,
  parameter int          CNT_WIDTH = 16,
  parameter int          TS_WIDTH  = 16,
  parameter int          GAP_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cfg_start,
  input  logic                 cfg_stop,
  input  logic [1:0]           cfg_mode,
  input  logic [CNT_WIDTH-1:0] cfg_pkt_count,
  input  logic [LEN_WIDTH-1:0] cfg_len,
  input  logic [LEN_WIDTH-1:0] cfg_len_max,
  input  logic [GAP_WIDTH-1:0] cfg_gap,
  input  logic [47:0]          cfg_src_mac,
  input  logic [47:0]          cfg_dst_mac,
  input  logic [TS_WIDTH-1:0]  timestamp,
  eth_pattern_gen_if.master    eth,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] sent_count
);

  typedef enum logic [1:0] {IDLE, HDR, PAYLOAD, GAP} state_t;

  state_t               state, state_next;
  logic                 burst_mode, sweep_mode;
  logic [CNT_WIDTH-1:0] pkt_count;
  logic [LEN_WIDTH-1:0] len_start, len_max, cur_len, eff_len, byte_idx;
  logic [GAP_WIDTH-1:0] gap_len, gap_cnt;
  logic [47:0]          src_mac, dst_mac;
  logic [TS_WIDTH-1:0]  ts_lat;
  logic                 stop_pending;
  logic                 start_ok, beat, tlast, last_beat, done_now, done_after;
  logic                 hdr_valid_c, tvalid_c;
  logic [15:0]          seq16, ts16;
  logic [7:0]           tdata;

  // Reserved mode 3 behaves as burst; a zero-length burst is never started.
  assign start_ok = cfg_start &&
                    !((cfg_mode != 2'd1) && (cfg_mode != 2'd2) && (cfg_pkt_count == '0));

  assign eff_len = (cur_len < LEN_WIDTH'(MIN_LEN)) ? LEN_WIDTH'(MIN_LEN) :
                   (cur_len > LEN_WIDTH'(MAX_LEN)) ? LEN_WIDTH'(MAX_LEN) : cur_len;

  assign tlast      = (state == PAYLOAD) && (byte_idx == eff_len - 1'b1);
  assign beat       = (state == PAYLOAD) && eth.payload_tready;
  assign last_beat  = beat && tlast;
  assign done_now   = burst_mode && (sent_count == pkt_count);
  assign done_after = burst_mode && ((sent_count + 1'b1) == pkt_count);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next  = state;
    hdr_valid_c = 1'b0;
    tvalid_c    = 1'b0;
    case (state)
      IDLE: if (start_ok) state_next = HDR;
      HDR: begin
        hdr_valid_c = 1'b1;
        // An accepted header always yields a complete frame, even with stop present.
        if (eth.hdr_ready)  state_next = PAYLOAD;
        else if (cfg_stop)  state_next = IDLE;
      end
      PAYLOAD: begin
        tvalid_c = 1'b1;
        if (last_beat) begin
          if (stop_pending || cfg_stop) state_next = IDLE;
          else if (gap_len != '0)       state_next = GAP;
          else if (done_after)          state_next = IDLE;
          else                          state_next = HDR;
        end
      end
      GAP: begin
        if (cfg_stop || ((gap_cnt == '0) && done_now)) state_next = IDLE;
        else if (gap_cnt == '0)                        state_next = HDR;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      burst_mode   <= 1'b0;
      sweep_mode   <= 1'b0;
      pkt_count    <= '0;
      len_start    <= '0;
      len_max      <= '0;
      cur_len      <= '0;
      byte_idx     <= '0;
      gap_len      <= '0;
      gap_cnt      <= '0;
      src_mac      <= '0;
      dst_mac      <= '0;
      ts_lat       <= '0;
      stop_pending <= 1'b0;
      sent_count   <= '0;
    end else begin
      case (state)
        IDLE: if (start_ok) begin
          burst_mode   <= (cfg_mode != 2'd1) && (cfg_mode != 2'd2);
          sweep_mode   <= (cfg_mode == 2'd2);
          pkt_count    <= cfg_pkt_count;
          len_start    <= cfg_len;
          len_max      <= cfg_len_max;
          cur_len      <= cfg_len;
          gap_len      <= cfg_gap;
          src_mac      <= cfg_src_mac;
          dst_mac      <= cfg_dst_mac;
          stop_pending <= 1'b0;
          sent_count   <= '0;
        end
        HDR: if (eth.hdr_ready) begin
          ts_lat       <= timestamp;
          byte_idx     <= '0;
          stop_pending <= cfg_stop;
        end
        PAYLOAD: begin
          if (cfg_stop) stop_pending <= 1'b1;
          if (beat) begin
            byte_idx <= byte_idx + 1'b1;
            if (tlast) begin
              sent_count <= sent_count + 1'b1;
              gap_cnt    <= gap_len - 1'b1;
              // Reload also covers len_max < len_start: every frame then uses len_start.
              if (sweep_mode)
                cur_len <= (cur_len >= len_max) ? len_start : cur_len + 1'b1;
            end
          end
        end
        GAP: if (gap_cnt != '0) gap_cnt <= gap_cnt - 1'b1;
        default: ;
      endcase
    end
  end

  assign seq16 = 16'(sent_count);
  assign ts16  = 16'(ts_lat);

  always_comb begin
    if (byte_idx == LEN_WIDTH'(0))      tdata = seq16[15:8];
    else if (byte_idx == LEN_WIDTH'(1)) tdata = seq16[7:0];
    else if (byte_idx == LEN_WIDTH'(2)) tdata = ts16[15:8];
    else if (byte_idx == LEN_WIDTH'(3)) tdata = ts16[7:0];
    else                                tdata = seq16[7:0] + byte_idx[7:0];
  end

  assign eth.hdr_valid      = hdr_valid_c;
  assign eth.dest_mac       = dst_mac;
  assign eth.src_mac        = src_mac;
  assign eth.eth_type       = ETH_TYPE;
  assign eth.payload_tdata  = tdata;
  assign eth.payload_tvalid = tvalid_c;
  assign eth.payload_tlast  = tlast;
  assign eth.payload_tuser  = 1'b0;
  assign busy               = (state != IDLE);

endmodule

// File: tb/tb_eth_pattern_gen.sv
// tb/tb_eth_pattern_gen.sv - scoreboard testbench for eth_pattern_gen
module tb_eth_pattern_gen;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_start = 1'b0;
  logic        cfg_stop = 1'b0;
  logic [1:0]  cfg_mode = 2'd0;
  logic [15:0] cfg_pkt_count = '0;
  logic [10:0] cfg_len = '0;
  logic [10:0] cfg_len_max = '0;
  logic [15:0] cfg_gap = '0;
  logic [47:0] cfg_src_mac = '0;
  logic [47:0] cfg_dst_mac = '0;
  logic [15:0] timestamp = '0;
  logic        busy;
  logic [15:0] sent_count;

  eth_pattern_gen_if eth();

  eth_pattern_gen dut (
    .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_stop(cfg_stop),
    .cfg_mode(cfg_mode), .cfg_pkt_count(cfg_pkt_count), .cfg_len(cfg_len),
    .cfg_len_max(cfg_len_max), .cfg_gap(cfg_gap), .cfg_src_mac(cfg_src_mac),
    .cfg_dst_mac(cfg_dst_mac), .timestamp(timestamp), .eth(eth),
    .busy(busy), .sent_count(sent_count)
  );

  always #4 clk = ~clk;

  typedef struct { int seq; int len; } frame_t;
  frame_t exp_q[$];

  int checks = 0, failures = 0;
  int run_gap = 0;
  logic [47:0] run_src = '0, run_dst = '0;
  bit arm = 0;
  int bp_en = 0;

  task automatic check(string name, longint act, longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Reference: frame k of a run, from the length rules alone.
  function automatic int model_len(int mode, int len0, int lmax, int k);
    int l;
    if (mode == 2 && lmax >= len0) l = len0 + (k % (lmax - len0 + 1));
    else                           l = len0;
    if (l < 4)    l = 4;
    if (l > 1500) l = 1500;
    return l;
  endfunction

  function automatic logic [7:0] exp_byte(int seq, logic [15:0] ts, int i);
    logic [15:0] s;
    s = seq[15:0];
    if (i == 0) return s[15:8];
    if (i == 1) return s[7:0];
    if (i == 2) return ts[15:8];
    if (i == 3) return ts[7:0];
    return 8'((seq + i) & 255);
  endfunction

  // Timestamp and ready drivers, updated just after each rising edge.
  initial begin
    eth.hdr_ready = 1'b1;
    eth.payload_tready = 1'b1;
    forever begin
      @(posedge clk); #1;
      timestamp = timestamp + 16'd1;
      eth.hdr_ready      = (bp_en != 0 && $urandom_range(0, 1) == 0) ? 1'b0 : 1'b1;
      eth.payload_tready = (bp_en != 0 && $urandom_range(0, 1) == 0) ? 1'b0 : 1'b1;
    end
  end

  // Monitor / scoreboard
  int cyc = 0, tlast_cyc = 0, hdr_count = 0, frames_done = 0, idx = 0, ferr = 0;
  int stall_err = 0, excl_err = 0;
  bit in_frame = 0, hstall = 0, pstall = 0, prev_hv = 0;
  frame_t cur;
  logic [15:0] cur_ts;
  logic [7:0]  ptd, e;
  logic        ptl;
  logic [47:0] hd, hs;

  always @(negedge clk) begin
    if (!rst_n) begin
      in_frame = 0; hstall = 0; pstall = 0; prev_hv = 0; arm = 0;
    end else begin
      cyc++;
      if (eth.hdr_valid && eth.payload_tvalid) excl_err++;
      if (hstall && (!eth.hdr_valid || eth.dest_mac != hd || eth.src_mac != hs)) stall_err++;
      if (pstall && (!eth.payload_tvalid || eth.payload_tdata != ptd || eth.payload_tlast != ptl)) stall_err++;
      hstall = eth.hdr_valid && !eth.hdr_ready && !cfg_stop;
      hd = eth.dest_mac; hs = eth.src_mac;
      pstall = eth.payload_tvalid && !eth.payload_tready;
      ptd = eth.payload_tdata; ptl = eth.payload_tlast;
      if (eth.hdr_valid && !prev_hv && arm) check("gap_cycles", cyc - tlast_cyc - 1, run_gap);
      prev_hv = eth.hdr_valid;
      if (eth.hdr_valid && eth.hdr_ready) begin
        hdr_count++;
        arm = 0;
        check("hdr_dst_mac", eth.dest_mac, run_dst);
        check("hdr_src_mac", eth.src_mac, run_src);
        check("hdr_eth_type", eth.eth_type, 16'h88B5);
        if (exp_q.size() == 0) check("unexpected_hdr", 1, 0);
        else begin
          cur = exp_q.pop_front();
          in_frame = 1; idx = 0; ferr = 0; cur_ts = timestamp;
        end
      end
      if (eth.payload_tvalid && eth.payload_tready) begin
        if (!in_frame) check("beat_outside_frame", 1, 0);
        else begin
          e = exp_byte(cur.seq, cur_ts, idx);
          if (eth.payload_tdata != e) ferr++;
          if (eth.payload_tlast != (idx == cur.len - 1)) ferr++;
          idx++;
          if (eth.payload_tlast) begin
            check("frame_len", idx, cur.len);
            check("frame_byte_errors", ferr, 0);
            in_frame = 0; frames_done++; arm = 1; tlast_cyc = cyc;
          end
        end
      end
    end
  end

  task automatic cycles(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_run(int mode, int cnt, int len0, int lmax, int gap, int nmodel);
    frame_t f;
    exp_q.delete();
    arm = 0;
    run_gap = gap;
    run_src = {$urandom, $urandom};
    run_dst = {$urandom, $urandom};
    for (int k = 0; k < nmodel; k++) begin
      f.seq = k & 16'hFFFF;
      f.len = model_len(mode, len0, lmax, k);
      exp_q.push_back(f);
    end
    @(posedge clk); #1;
    cfg_mode = mode[1:0]; cfg_pkt_count = cnt[15:0]; cfg_len = len0[10:0];
    cfg_len_max = lmax[10:0]; cfg_gap = gap[15:0];
    cfg_src_mac = run_src; cfg_dst_mac = run_dst;
    cfg_start = 1'b1;
    @(posedge clk); #1;
    cfg_start = 1'b0;
    // Configuration must be frozen after the start edge.
    cfg_mode = 2'($urandom); cfg_pkt_count = 16'($urandom); cfg_len = 11'($urandom);
    cfg_len_max = 11'($urandom); cfg_gap = 16'($urandom);
    cfg_src_mac = {$urandom, $urandom}; cfg_dst_mac = {$urandom, $urandom};
  endtask

  task automatic pulse_stop();
    @(posedge clk); #1;
    cfg_stop = 1'b1;
    @(posedge clk); #1;
    cfg_stop = 1'b0;
  endtask

  task automatic wait_idle(int budget);
    int n = 0;
    while (busy && n < budget) begin @(posedge clk); #1; n++; end
    check("idle_timeout", busy, 0);
  endtask

  task automatic wait_frames(int target, int budget);
    int n = 0;
    while (frames_done < target && n < budget) begin @(posedge clk); #1; n++; end
    check("frames_timeout", frames_done >= target, 1);
  endtask

  task automatic wait_mid_frame(int min_idx, int budget);
    int n = 0;
    while (!(in_frame && idx >= min_idx) && n < budget) begin @(posedge clk); #1; n++; end
    check("mid_frame_timeout", in_frame && idx >= min_idx, 1);
  endtask

  initial begin
    int f0, h, busy_hits, len0, gap;
    #4000000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int f0, h, busy_hits, len0, gap;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_hdr_valid", eth.hdr_valid, 0);
    check("rst_tvalid", eth.payload_tvalid, 0);
    check("rst_tlast", eth.payload_tlast, 0);
    check("rst_tuser", eth.payload_tuser, 0);
    check("rst_sent_count", sent_count, 0);
    rst_n = 1'b1;
    cycles(2);

    // Burst of three 64-byte frames, gap 10
    f0 = frames_done;
    start_run(0, 3, 64, 0, 10, 3);
    wait_idle(2000);
    check("burst_sent_count", sent_count, 3);
    check("burst_frames", frames_done - f0, 3);
    check("burst_queue_left", exp_q.size(), 0);

    // Length clamping, including gap 0
    f0 = frames_done;
    start_run(0, 2, 1, 0, 0, 2);
    wait_idle(500);
    check("clamp_min_frames", frames_done - f0, 2);
    f0 = frames_done;
    start_run(3, 1, 2000, 0, 3, 1);
    wait_idle(3000);
    check("clamp_max_frames", frames_done - f0, 1);

    // Sweep 60..62, stop mid-frame
    f0 = frames_done;
    start_run(2, 0, 60, 62, 2, 64);
    wait_frames(f0 + 5, 2000);
    wait_mid_frame(10, 500);
    pulse_stop();
    wait_idle(500);
    check("sweep_frames", frames_done - f0, 6);
    check("sweep_sent_count", sent_count, 6);
    h = hdr_count;
    cycles(50);
    check("sweep_no_hdr_after_stop", hdr_count - h, 0);

    // Random backpressure, 20 packets in two bursts
    bp_en = 1;
    for (int r = 0; r < 2; r++) begin
      len0 = $urandom_range(1, 90);
      gap = $urandom_range(0, 3);
      f0 = frames_done;
      start_run(0, 10, len0, 0, gap, 10);
      wait_idle(10000);
      check("bp_frames", frames_done - f0, 10);
      check("bp_sent_count", sent_count, 10);
    end
    // Sweep with len_max below start length, stopped at an arbitrary point
    f0 = frames_done;
    start_run(2, 0, 20, 10, 1, 64);
    wait_frames(f0 + 3, 2000);
    cycles($urandom_range(0, 20));
    pulse_stop();
    wait_idle(500);
    check("sweep_rev_sent_count", sent_count, frames_done - f0);
    bp_en = 0;
    cycles(2);

    // Start while busy is ignored
    f0 = frames_done;
    start_run(0, 4, 30, 0, 5, 4);
    cycles(40);
    cfg_mode = 2'd1; cfg_pkt_count = 16'd9; cfg_start = 1'b1;
    cycles(1);
    cfg_start = 1'b0;
    wait_idle(2000);
    check("busy_start_sent_count", sent_count, 4);
    check("busy_start_frames", frames_done - f0, 4);

    // Burst count 0
    h = hdr_count;
    busy_hits = 0;
    start_run(0, 0, 64, 0, 0, 0);
    repeat (20) begin
      if (busy) busy_hits++;
      cycles(1);
    end
    check("cnt0_busy", busy_hits, 0);
    check("cnt0_headers", hdr_count - h, 0);

    // Asynchronous reset mid-payload
    start_run(1, 0, 100, 0, 0, 64);
    wait_mid_frame(5, 500);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("arst_hdr_valid", eth.hdr_valid, 0);
    check("arst_tvalid", eth.payload_tvalid, 0);
    check("arst_tlast", eth.payload_tlast, 0);
    check("arst_busy", busy, 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("arst_sent_count", sent_count, 0);
    cycles(2);
    f0 = frames_done;
    start_run(0, 2, 8, 0, 1, 2);
    wait_idle(500);
    check("post_rst_frames", frames_done - f0, 2);
    check("post_rst_sent_count", sent_count, 2);

    check("stall_violations", stall_err, 0);
    check("hdr_payload_overlap", excl_err, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
